// File: rtl/pixel_drain.sv
// pixel_drain: walks a finished frame out of the solver result memories in raster order.
// One read is issued per cycle while credit allows. A valid-only delay line re-aligns
// each returned iteration count with its coordinates. Results then pass through a skid
// FIFO with a registered head into a valid/ready pixel stream.
module pixel_drain #(
    parameter int unsigned NUM_SOLVERS = 7,
    parameter int unsigned NUM_COLUMNS = 99,
    parameter int unsigned NUM_ROWS    = 66,
    parameter int unsigned RD_LATENCY  = 2,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned ITER_WIDTH  = 8,
    parameter int unsigned ID_WIDTH    = 6,
    parameter int unsigned ADDR_WIDTH  = 19,
    parameter int unsigned COL_WIDTH   = 10,
    parameter int unsigned ROW_WIDTH   = 10
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  loop,
    output logic                  rd_en,
    output logic [ID_WIDTH-1:0]   rd_solver_id,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [ITER_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ITER_WIDTH-1:0] out_data,
    output logic [COL_WIDTH-1:0]  out_col,
    output logic [ROW_WIDTH-1:0]  out_row,
    output logic                  out_last,
    output logic                  busy,
    output logic                  frame_done
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CrdW = $clog2(RD_LATENCY + FIFO_DEPTH + 1);

    localparam logic [COL_WIDTH-1:0] LastCol = COL_WIDTH'(NUM_COLUMNS - 1);
    localparam logic [ROW_WIDTH-1:0] LastRow = ROW_WIDTH'(NUM_ROWS - 1);
    localparam logic [ID_WIDTH-1:0]  LastSid = ID_WIDTH'(NUM_SOLVERS - 1);
    localparam logic [PtrW-1:0]      LastPtr = PtrW'(FIFO_DEPTH - 1);
    localparam logic [CrdW-1:0]      Credits = CrdW'(FIFO_DEPTH);

    typedef struct packed {
        logic [COL_WIDTH-1:0] col;
        logic [ROW_WIDTH-1:0] row;
        logic                 last;
    } tag_t;

    typedef struct packed {
        logic [ITER_WIDTH-1:0] data;
        tag_t                  tag;
    } pix_t;

    logic [1:0]            state_q, state_d;
    logic [COL_WIDTH-1:0]  col_q, col_d;
    logic [ROW_WIDTH-1:0]  row_q, row_d;
    logic [ID_WIDTH-1:0]   sid_q, sid_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    logic                  stage_valid_q [RD_LATENCY];
    tag_t                  stage_tag_q   [RD_LATENCY];

    pix_t                  fifo_mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       fifo_count_q, fifo_count_d;

    pix_t                  out_q, out_d;
    logic                  out_valid_q, out_valid_d;
    logic                  frame_done_q;

    logic                  clear;
    logic                  issue;
    logic                  last_pix;
    logic                  credit_ok;
    logic [CrdW-1:0]       in_flight;
    logic                  pop;
    logic                  push;
    pix_t                  push_pix;
    logic                  fifo_wr;
    logic                  fifo_rd;

    // Credit: in-flight reads plus entries parked behind the head register. The head
    // register is not counted, so a full pipeline still streams one pixel per cycle.
    always_comb begin
        in_flight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            in_flight = in_flight + CrdW'(stage_valid_q[i]);
        end
        credit_ok = (in_flight + CrdW'(fifo_count_q)) < Credits;
    end

    assign last_pix = (col_q == LastCol) && (row_q == LastRow);
    assign issue    = (state_q == StIssue) && credit_ok;
    assign pop      = out_valid_q && out_ready;
    assign push     = stage_valid_q[RD_LATENCY-1];
    assign push_pix = '{data: rd_data, tag: stage_tag_q[RD_LATENCY-1]};

    // Frame sequencing: IDLE -> ISSUE -> DRAIN -> (ISSUE when looping | IDLE).
    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        case (state_q)
            StIdle: begin
                clear = 1'b1;
                if (start) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (issue && last_pix) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (pop && out_q.tag.last) begin
                    clear   = 1'b1;
                    state_d = loop ? StIssue : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Issue-side counters; solver/word and column/row advance by wrap rather than division.
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        sid_d  = sid_q;
        addr_d = addr_q;
        if (clear) begin
            col_d  = '0;
            row_d  = '0;
            sid_d  = '0;
            addr_d = '0;
        end else if (issue) begin
            if (sid_q == LastSid) begin
                sid_d  = '0;
                addr_d = addr_q + ADDR_WIDTH'(1);
            end else begin
                sid_d = sid_q + ID_WIDTH'(1);
            end
            if (col_q == LastCol) begin
                col_d = '0;
                row_d = row_q + ROW_WIDTH'(1);
            end else begin
                col_d = col_q + COL_WIDTH'(1);
            end
        end
    end

    // Head register refill: from storage first, else straight from the delay line.
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q && !pop;
        fifo_wr     = 1'b0;
        fifo_rd     = 1'b0;
        if (!out_valid_q || pop) begin
            if (fifo_count_q != '0) begin
                out_d       = fifo_mem_q[rd_ptr_q];
                out_valid_d = 1'b1;
                fifo_rd     = 1'b1;
                fifo_wr     = push;
            end else if (push) begin
                out_d       = push_pix;
                out_valid_d = 1'b1;
            end
        end else begin
            fifo_wr = push;
        end
        wr_ptr_d     = fifo_wr ? ((wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1)) : wr_ptr_q;
        rd_ptr_d     = fifo_rd ? ((rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1)) : rd_ptr_q;
        fifo_count_d = fifo_count_q + CntW'(fifo_wr) - CntW'(fifo_rd);
    end

    // State and issue counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            col_q   <= '0;
            row_q   <= '0;
            sid_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            sid_q   <= sid_d;
            addr_q  <= addr_d;
        end
    end

    // Alignment delay line; clearing the valid bits on reset discards reads in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                stage_valid_q[i] <= 1'b0;
                stage_tag_q[i]   <= '0;
            end
        end else begin
            stage_valid_q[0] <= issue;
            stage_tag_q[0]   <= '{col: col_q, row: row_q, last: last_pix};
            for (int i = 1; i < RD_LATENCY; i++) begin
                stage_valid_q[i] <= stage_valid_q[i-1];
                stage_tag_q[i]   <= stage_tag_q[i-1];
            end
        end
    end

    // Skid storage, head register and frame-done pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            if (fifo_wr) begin
                fifo_mem_q[wr_ptr_q] <= push_pix;
            end
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= pop && out_q.tag.last;
        end
    end

    assign rd_en        = issue;
    assign rd_solver_id = sid_q;
    assign rd_addr      = addr_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_q.data;
    assign out_col      = out_q.tag.col;
    assign out_row      = out_q.tag.row;
    assign out_last     = out_q.tag.last;
    assign busy         = state_q != StIdle;
    assign frame_done   = frame_done_q;

endmodule
